arith_ctrl_seq: RTL and testbench

Parametrised micro-op sequencer for the arithmetic processor datapath. It accepts encoded micro-ops over a valid/ready handshake and drives single-cycle strobes for the M/A/Q registers, shifter and ALU operand muxes. It also runs a counted shift-add multiply sequence whose length follows the datapath width. Unlike earlier control units, every strobe is a one-cycle pulse, the register-select width scales with the register count, and completion and error are reported explicitly.

---
 rtl/arith_ctrl_seq_if.sv | 36 +++
 rtl/arith_ctrl_seq.sv | 156 +++++++++++++++
 tb/tb_arith_ctrl_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/arith_ctrl_seq_if.sv
// Micro-op handshake and datapath strobe bundle for arith_ctrl_seq.
// The select width follows the number of ALU operand sources.
interface arith_ctrl_seq_if #(
  parameter int NREG = 4
);
  localparam int SELW = $clog2(NREG);

  logic [4+2*SELW-1:0] uop;
  logic                uop_valid;
  logic                uop_ready;
  logic                ldm;
  logic                lda;
  logic                ldq;
  logic                sl;
  logic                sr;
  logic                srsel;
  logic [SELW-1:0]     asel;
  logic [SELW-1:0]     bsel;
  logic                mulst;
  logic                mulsel;
  logic                dprst;
  logic                done;
  logic                err;

  modport master (
    output uop, uop_valid,
    input  uop_ready, ldm, lda, ldq, sl, sr, srsel, asel, bsel,
    input  mulst, mulsel, dprst, done, err
  );

  modport slave (
    input  uop, uop_valid,
    output uop_ready, ldm, lda, ldq, sl, sr, srsel, asel, bsel,
    output mulst, mulsel, dprst, done, err
  );
endinterface

// File: rtl/arith_ctrl_seq.sv
// Micro-op sequencer: turns accepted micro-ops into one-cycle registered datapath
// strobes and runs a WIDTH-cycle shift-add multiply sequence.
module arith_ctrl_seq #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
) (
  input logic             i_clk,
  input logic             i_rst_n,
  arith_ctrl_seq_if.slave bus
);
  localparam int SELW = $clog2(NREG);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_DPRST = 4'd1;
  localparam logic [3:0] OP_LDM   = 4'd2;
  localparam logic [3:0] OP_LDQ   = 4'd3;
  localparam logic [3:0] OP_SL    = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SRA   = 4'd6;
  localparam logic [3:0] OP_ALU   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MSTART,
    S_MRUN,
    S_MWB
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;

  logic [3:0]      w_op;
  logic [SELW-1:0] w_asel_f;
  logic [SELW-1:0] w_bsel_f;
  logic            w_ready;
  logic            w_acc;
  logic            w_mul_last;

  logic            r_ldm, r_lda, r_ldq, r_sl, r_sr, r_srsel;
  logic            r_mulst, r_mulsel, r_dprst, r_done, r_err;
  logic [SELW-1:0] r_asel, r_bsel;

  logic            w_ldm, w_lda, w_ldq, w_sl, w_sr, w_srsel;
  logic            w_mulst, w_mulsel, w_dprst, w_done, w_err;
  logic [SELW-1:0] w_asel, w_bsel;

  assign w_op       = bus.uop[4+2*SELW-1 -: 4];
  assign w_asel_f   = bus.uop[2*SELW-1 -: SELW];
  assign w_bsel_f   = bus.uop[SELW-1:0];
  assign w_ready    = (r_state == S_IDLE) || (r_state == S_EXEC) || (r_state == S_MWB);
  assign w_acc      = bus.uop_valid && w_ready;
  assign w_mul_last = (r_state == S_MRUN) && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Counter saturates at LAST so it can never wrap.
      if (r_state == S_MSTART)
        r_cnt <= '0;
      else if ((r_state == S_MRUN) && (r_cnt != LAST))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_EXEC, S_MWB: begin
        if (w_acc)
          w_state_nxt = (w_op == OP_MUL) ? S_MSTART : S_EXEC;
        else
          w_state_nxt = S_IDLE;
      end
      S_MSTART: w_state_nxt = S_MRUN;
      S_MRUN:   if (r_cnt == LAST) w_state_nxt = S_MWB;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the output registers, decoded from the op being accepted now.
  always_comb begin
    w_ldm    = w_acc && (w_op == OP_LDM);
    w_ldq    = (w_acc && (w_op == OP_LDQ)) || w_mul_last;
    w_lda    = (w_acc && (w_op == OP_ALU)) || w_mul_last;
    w_sl     = w_acc && (w_op == OP_SL);
    w_sr     = w_acc && ((w_op == OP_SRL) || (w_op == OP_SRA));
    w_mulst  = w_acc && (w_op == OP_MUL);
    w_mulsel = w_mul_last;
    w_dprst  = w_acc && (w_op == OP_DPRST);
    w_done   = (w_acc && (w_op != OP_MUL)) || w_mul_last;
    w_err    = w_acc && (w_op > OP_MUL);
    w_srsel  = r_srsel;
    if (w_acc && (w_op == OP_SRL)) w_srsel = 1'b0;
    if (w_acc && (w_op == OP_SRA)) w_srsel = 1'b1;
    w_asel   = r_asel;
    w_bsel   = r_bsel;
    if (w_acc && (w_op == OP_ALU)) begin
      w_asel = w_asel_f;
      w_bsel = w_bsel_f;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ldm    <= 1'b0;
      r_lda    <= 1'b0;
      r_ldq    <= 1'b0;
      r_sl     <= 1'b0;
      r_sr     <= 1'b0;
      r_srsel  <= 1'b0;
      r_mulst  <= 1'b0;
      r_mulsel <= 1'b0;
      r_dprst  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_asel   <= '0;
      r_bsel   <= '0;
    end else begin
      r_ldm    <= w_ldm;
      r_lda    <= w_lda;
      r_ldq    <= w_ldq;
      r_sl     <= w_sl;
      r_sr     <= w_sr;
      r_srsel  <= w_srsel;
      r_mulst  <= w_mulst;
      r_mulsel <= w_mulsel;
      r_dprst  <= w_dprst;
      r_done   <= w_done;
      r_err    <= w_err;
      r_asel   <= w_asel;
      r_bsel   <= w_bsel;
    end
  end

  assign bus.uop_ready = w_ready;
  assign bus.ldm       = r_ldm;
  assign bus.lda       = r_lda;
  assign bus.ldq       = r_ldq;
  assign bus.sl        = r_sl;
  assign bus.sr        = r_sr;
  assign bus.srsel     = r_srsel;
  assign bus.asel      = r_asel;
  assign bus.bsel      = r_bsel;
  assign bus.mulst     = r_mulst;
  assign bus.mulsel    = r_mulsel;
  assign bus.dprst     = r_dprst;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_arith_ctrl_seq.sv
// Directed-vector bench for arith_ctrl_seq: a WIDTH=8/NREG=4 instance and a
// WIDTH=16/NREG=8 instance share clock and reset.
module tb_arith_ctrl_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  arith_ctrl_seq_if #(.NREG(4)) bus8 ();
  arith_ctrl_seq_if #(.NREG(8)) bus16 ();

  arith_ctrl_seq #(.WIDTH(8), .NREG(4)) u_dut8 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus8)
  );

  arith_ctrl_seq #(.WIDTH(16), .NREG(8)) u_dut16 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus16)
  );

  localparam logic [10:0] S_LDM    = 11'h400;
  localparam logic [10:0] S_LDA    = 11'h200;
  localparam logic [10:0] S_LDQ    = 11'h100;
  localparam logic [10:0] S_SL     = 11'h080;
  localparam logic [10:0] S_SR     = 11'h040;
  localparam logic [10:0] S_SRSEL  = 11'h020;
  localparam logic [10:0] S_MULST  = 11'h010;
  localparam logic [10:0] S_MULSEL = 11'h008;
  localparam logic [10:0] S_DPRST  = 11'h004;
  localparam logic [10:0] S_DONE   = 11'h002;
  localparam logic [10:0] S_ERR    = 11'h001;

  localparam logic [3:0] OP_NOP = 4'd0, OP_DPRST = 4'd1, OP_LDM = 4'd2, OP_LDQ = 4'd3;
  localparam logic [3:0] OP_SL  = 4'd4, OP_SRL = 4'd5, OP_SRA = 4'd6, OP_ALU = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8, OP_ILL = 4'd12;

  logic [10:0] st8, st16;
  assign st8  = {bus8.ldm, bus8.lda, bus8.ldq, bus8.sl, bus8.sr, bus8.srsel,
                 bus8.mulst, bus8.mulsel, bus8.dprst, bus8.done, bus8.err};
  assign st16 = {bus16.ldm, bus16.lda, bus16.ldq, bus16.sl, bus16.sr, bus16.srsel,
                 bus16.mulst, bus16.mulsel, bus16.dprst, bus16.done, bus16.err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, then sample 1 ns after the accepting rising edge.
  task automatic step8(input logic v, input logic [3:0] op, input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    bus8.uop       = {op, a, b};
    bus8.uop_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step16(input logic v, input logic [3:0] op, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    bus16.uop       = {op, a, b};
    bus16.uop_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus8.uop        = '0;
    bus8.uop_valid  = 1'b0;
    bus16.uop       = '0;
    bus16.uop_valid = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_strobes", st8, S_DPRST);
    chk("rst_async_sel", {bus8.asel, bus8.bsel}, 4'b0000);
    chk("rst_async_w16", st16, S_DPRST);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_dprst_held", st8, S_DPRST);
    @(posedge clk);
    #1;
    chk("rst_release_strobes", st8, 11'h000);
    chk("rst_release_ready", bus8.uop_ready, 1);

    // Back-to-back single-cycle ops
    step8(1'b1, OP_LDM, 2'd0, 2'd0);
    chk("b2b_ldm", st8, S_LDM | S_DONE);
    step8(1'b1, OP_LDQ, 2'd0, 2'd0);
    chk("b2b_ldq", st8, S_LDQ | S_DONE);
    step8(1'b1, OP_SRA, 2'd0, 2'd0);
    chk("b2b_sra", st8, S_SR | S_SRSEL | S_DONE);
    step8(1'b1, OP_ALU, 2'd2, 2'd3);
    chk("b2b_alu", st8, S_LDA | S_SRSEL | S_DONE);
    chk("b2b_alu_sel", {bus8.asel, bus8.bsel}, 4'b1011);
    step8(1'b0, OP_NOP, 2'd0, 2'd0);
    chk("b2b_idle_hold", st8, S_SRSEL);
    chk("b2b_idle_sel_hold", {bus8.asel, bus8.bsel}, 4'b1011);

    // Remaining single-cycle ops and the illegal op
    step8(1'b1, OP_SRL, 2'd1, 2'd1);
    chk("op_srl", st8, S_SR | S_DONE);
    step8(1'b1, OP_SL, 2'd0, 2'd0);
    chk("op_sl", st8, S_SL | S_DONE);
    step8(1'b1, OP_DPRST, 2'd0, 2'd0);
    chk("op_dprst", st8, S_DPRST | S_DONE);
    step8(1'b1, OP_NOP, 2'd0, 2'd0);
    chk("op_nop", st8, S_DONE);
    step8(1'b1, OP_ILL, 2'd1, 2'd2);
    chk("op_illegal", st8, S_DONE | S_ERR);
    chk("op_illegal_ready", bus8.uop_ready, 1);
    chk("op_illegal_sel_hold", {bus8.asel, bus8.bsel}, 4'b1011);
    step8(1'b0, OP_NOP, 2'd0, 2'd0);
    chk("op_illegal_after", st8, 11'h000);

    // WIDTH=8 multiply with an LDM offered while busy
    step8(1'b1, OP_MUL, 2'd0, 2'd0);
    chk("mul_start", st8, S_MULST);
    chk("mul_start_ready", bus8.uop_ready, 0);
    for (int c = 2; c <= 9; c++) begin
      step8(1'b1, OP_LDM, 2'd0, 2'd0);
      chk("mul_run", st8, 11'h000);
      chk("mul_run_ready", bus8.uop_ready, 0);
    end
    step8(1'b1, OP_LDM, 2'd0, 2'd0);
    chk("mul_wb", st8, S_LDA | S_LDQ | S_MULSEL | S_DONE);
    chk("mul_wb_ready", bus8.uop_ready, 1);
    step8(1'b0, OP_NOP, 2'd0, 2'd0);
    chk("mul_after_no_ldm", st8, 11'h000);

    // Reset in cycle 5 of a multiply
    step8(1'b1, OP_MUL, 2'd0, 2'd0);
    repeat (3) step8(1'b0, OP_NOP, 2'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_clear", st8, S_DPRST);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step8(1'b0, OP_NOP, 2'd0, 2'd0);
      chk("abort_no_wb", st8, 11'h000);
    end
    step8(1'b1, OP_MUL, 2'd0, 2'd0);
    chk("mul2_start", st8, S_MULST);
    for (int c = 2; c <= 10; c++) begin
      step8(1'b0, OP_NOP, 2'd0, 2'd0);
      chk("mul2_done", bus8.done, (c == 10) ? 1 : 0);
    end

    // WIDTH=16, NREG=8 instance
    step16(1'b1, OP_ALU, 3'd7, 3'd5);
    chk("w16_alu", st16, S_LDA | S_DONE);
    chk("w16_asel", bus16.asel, 3'b111);
    chk("w16_bsel", bus16.bsel, 3'b101);
    step16(1'b1, OP_MUL, 3'd0, 3'd0);
    chk("w16_mulst", st16, S_MULST);
    for (int c = 2; c <= 18; c++) begin
      step16(1'b0, OP_NOP, 3'd0, 3'd0);
      chk("w16_done", bus16.done, (c == 18) ? 1 : 0);
    end
    chk("w16_wb", st16, S_LDA | S_LDQ | S_MULSEL | S_DONE);
    step16(1'b0, OP_NOP, 3'd0, 3'd0);
    chk("w16_after", st16, 11'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
